ex_wb_stage: RTL
================

Name: ex_wb_stage

Overview:
- Execute/write-back stage that consumes the ID/EX pipeline register outputs.
- Performs the ALU operation and presents a registered register-file write port (data, address, enable).
- Single-cycle ops complete in one cycle; MUL runs on an iterative shift-add engine and holds the upstream pipeline with a stall signal.
- Sits between the ID/EX register and the register-file write port.

Parameters:
- WIDTH, 32, datapath width in bits.
- MUL_STEP, 1, multiplier bits retired per cycle; must divide WIDTH evenly; MUL busy time is WIDTH/MUL_STEP cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ID/EX contents hold a live instruction.
- Rs_data_in  input  WIDTH  operand A.
- Rt_data_in  input  WIDTH  operand B.
- Funct_ctrl_in  input  6  R-type funct field.
- shamt_in  input  5  shift amount.
- Rd_addr_in  input  5  destination register.
- ALU_op_in  input  2  00 add, 01 sub, 10 R-type (decode funct), 11 reserved.
- Reg_w_in  input  1  instruction writes a register.
- stall  output  1  upstream must hold ID/EX contents.
- Rd_data_out  output  WIDTH  write-back data.
- Rd_addr_out  output  5  write-back address.
- Reg_w_out  output  1  write enable, one-cycle pulse per completed instruction.

Behaviour:
- Reset: Rd_data_out=0, Rd_addr_out=0, Reg_w_out=0, stall=0, FSM=IDLE, step counter=0, multiplier accumulator/operands=0.
- Reset asserted mid-MUL aborts the operation; no write pulse is produced for it.
- Accept rule: an instruction is accepted on a rising edge where in_valid=1 and stall=0. Inputs are ignored while stall=1.
- FSM states are IDLE and MUL_BUSY.
- IDLE, non-MUL accepted:
  - Next edge: Rd_data_out = result, Rd_addr_out = Rd_addr_in, Reg_w_out = Reg_w_in.
  - Latency is 1 cycle; FSM stays IDLE.
- IDLE, no accept: Reg_w_out=0. Rd_data_out and Rd_addr_out hold their previous values.
- Op decode for ALU_op=10:
  - 6'h20 add, 6'h22 sub, 6'h24 and, 6'h25 or.
  - 6'h2a slt (signed; result 1 or 0).
  - 6'h00 sll Rt by shamt; 6'h02 srl Rt by shamt (logical).
  - 6'h18 MUL: low WIDTH bits of the unsigned product Rs*Rt.
- Add and sub wrap modulo 2^WIDTH. No overflow trap.
- Unsupported op (ALU_op=11 or unknown funct): Rd_data_out=0, Reg_w_out=0, completes in 1 cycle.
- MUL accepted in IDLE:
  - Latch operands, Rd_addr_in and Reg_w_in. Set counter = WIDTH/MUL_STEP. Go to MUL_BUSY. Reg_w_out=0.
  - stall is combinational: high whenever FSM=MUL_BUSY.
  - MUL_BUSY, each edge: retire MUL_STEP multiplier bits and decrement the counter.
  - On the edge where the counter reaches 0: Rd_data_out = product, Rd_addr_out = latched address, Reg_w_out = latched Reg_w for one cycle, FSM returns to IDLE. stall drops in that cycle.
  - Total with MUL_STEP=1: accepted at edge N, stall high for cycles N+1..N+32, Reg_w_out high in cycle N+33. The next instruction can be accepted at edge N+33.
- Back-to-back: a new instruction is accepted on the same edge that a single-cycle result is registered. No bubble between single-cycle ops.
- Rd_addr=0: written like any other address; suppressing writes to register 0 is the register file's job.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: MUL engine, MUL_BUSY state and stall logic are built as described above.
- Undefined: funct 6'h18 is treated as unsupported (result 0, Reg_w_out=0, 1-cycle latency). stall is tied to 0. No multiplier or counter hardware is built.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> all outputs 0, stall=0 throughout.
- R-type add: Rs=5, Rt=7, funct 6'h20, Rd=3, Reg_w=1 -> next cycle Rd_data_out=12, Rd_addr_out=3, Reg_w_out=1 for exactly 1 cycle. Also add 32'hFFFFFFFF+1 -> 0.
- slt and shift: Rs=32'hFFFFFFFE, Rt=1, funct 6'h2a -> 1. Rt=32'h80000001, shamt=4, sll -> 32'h00000010; srl -> 32'h08000000.
- MUL (EX_MUL_EN defined): Rs=1234, Rt=5678, Rd=9 -> stall high for 32 cycles, then Rd_data_out=7006652 with Reg_w_out pulse on Rd=9. Change the inputs mid-stall -> result unaffected.
- Reset at MUL step 10 -> FSM=IDLE and stall=0 next cycle, no Reg_w_out pulse. A following add executes normally.
- Unsupported ALU_op=11 with Reg_w=1 -> Reg_w_out stays 0. With EX_MUL_EN undefined, funct 6'h18 -> Reg_w_out=0 and stall never asserts.

Source files
------------

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute/write-back stage driving a registered register-file write port.
// Define EX_MUL_EN to build the iterative shift-add multiplier (funct 6'h18) and its stall logic.
module ex_wb_stage #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] Rs_data_in,
    input  logic [WIDTH-1:0] Rt_data_in,
    input  logic [5:0]       Funct_ctrl_in,
    input  logic [4:0]       shamt_in,
    input  logic [4:0]       Rd_addr_in,
    input  logic [1:0]       ALU_op_in,
    input  logic             Reg_w_in,
    output logic             stall,
    output logic [WIDTH-1:0] Rd_data_out,
    output logic [4:0]       Rd_addr_out,
    output logic             Reg_w_out
);

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ok;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;

    assign accept = in_valid & ~stall;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
        alu_res = '0;
        alu_ok  = 1'b0;
        is_mul  = 1'b0;
        case (ALU_op_in)
            2'b00: begin alu_res = Rs_data_in + Rt_data_in; alu_ok = 1'b1; end
            2'b01: begin alu_res = Rs_data_in - Rt_data_in; alu_ok = 1'b1; end
            2'b10: begin
                case (Funct_ctrl_in)
                    F_ADD: begin alu_res = Rs_data_in + Rt_data_in; alu_ok = 1'b1; end
                    F_SUB: begin alu_res = Rs_data_in - Rt_data_in; alu_ok = 1'b1; end
                    F_AND: begin alu_res = Rs_data_in & Rt_data_in; alu_ok = 1'b1; end
                    F_OR:  begin alu_res = Rs_data_in | Rt_data_in; alu_ok = 1'b1; end
                    F_SLT: begin
                        alu_res = {{(WIDTH-1){1'b0}}, ($signed(Rs_data_in) < $signed(Rt_data_in))};
                        alu_ok  = 1'b1;
                    end
                    F_SLL: begin alu_res = Rt_data_in << shamt_in; alu_ok = 1'b1; end
                    F_SRL: begin alu_res = Rt_data_in >> shamt_in; alu_ok = 1'b1; end
`ifdef EX_MUL_EN
                    6'h18: is_mul = 1'b1;
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

    localparam int MUL_CYCLES = WIDTH / MUL_STEP;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       mul_addr_q, mul_addr_d;
    logic             mul_w_q, mul_w_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mul_addr_d = mul_addr_q;
        mul_w_d    = mul_w_q;
        mul_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d    = MUL_BUSY;
                    cnt_d      = CNT_W'(MUL_CYCLES);
                    mcand_d    = Rs_data_in;
                    mplier_d   = Rt_data_in;
                    acc_d      = '0;
                    mul_addr_d = Rd_addr_in;
                    mul_w_d    = Reg_w_in;
                end
            end
            MUL_BUSY: begin
                // Retire MUL_STEP multiplier bits; only the low WIDTH product bits are kept.
                for (int i = 0; i < MUL_STEP; i++) begin
                    if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
                end
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mul_addr_q <= '0;
            mul_w_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            mul_addr_q <= mul_addr_d;
            mul_w_q    <= mul_w_d;
        end
    end

    assign mul_result = acc_d;
    assign stall      = (state_q == MUL_BUSY);
`else
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign stall      = 1'b0;
`endif

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic             reg_w_q, reg_w_d;

    always_comb begin
        rd_data_d = rd_data_q;
        rd_addr_d = rd_addr_q;
        reg_w_d   = 1'b0;
        if (mul_done) begin
            rd_data_d = mul_result;
`ifdef EX_MUL_EN
            rd_addr_d = mul_addr_q;
            reg_w_d   = mul_w_q;
`endif
        end else if (accept && !is_mul) begin
            // Unsupported ops still complete in one cycle but never write.
            rd_data_d = alu_ok ? alu_res : '0;
            rd_addr_d = Rd_addr_in;
            reg_w_d   = Reg_w_in & alu_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_addr_q <= '0;
            reg_w_q   <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr_d;
            reg_w_q   <= reg_w_d;
        end
    end

    assign Rd_data_out = rd_data_q;
    assign Rd_addr_out = rd_addr_q;
    assign Reg_w_out   = reg_w_q;

endmodule
